// File: rtl/pcs_pkg.sv
// Shared PCS transmit types and constants for the
// 64b/66b gearbox sequence controller.
package pcs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_RUN,
        ST_PAUSE
    } state_t;

    localparam int SEQ_WIDTH = 6;
    localparam logic [SEQ_WIDTH-1:0] SEQ_MAX = 6'd63;
    localparam int PAUSE_CYCLES = 2;
    localparam int HEADER_WIDTH = 2;
    localparam int DATA_WIDTH = 32;

endpackage

// File: rtl/pcs_seq_counter.sv
// Gearbox sequence counter: wraps after SEQ_MAX,
// holds while hold is set, clear has priority.
module pcs_seq_counter
    import pcs_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 hold,
    output logic [SEQ_WIDTH-1:0] count,
    output logic                 at_max
);

    assign at_max = (count == SEQ_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (!hold) begin
            count <= at_max ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/tx_gearbox_ctrl.sv
// TX gearbox control FSM (IDLE/START/RUN/PAUSE) with idle insertion.
// Optional statistics counters: define TX_GEARBOX_CTRL_STATS_EN.
module tx_gearbox_ctrl
    import pcs_pkg::*;
#(
    parameter int START_DELAY = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_enable,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic [SEQ_WIDTH-1:0] o_gearbox_seq,
    output logic                 o_pause,
    output logic                 o_insert_idle,
    output logic                 o_underflow,
`ifdef TX_GEARBOX_CTRL_STATS_EN
    output logic                 o_running,
    output logic [31:0]          o_block_count,
    output logic [15:0]          o_idle_count
`else
    output logic                 o_running
`endif
);

    logic [1:0] rst_sync;
    logic       rst_n;
    state_t     state;
    logic [3:0] delay_cnt;
    logic [1:0] pause_cnt;
    logic       idle_odd;
    logic       even_xfer;
    logic       seq_at_max;
    logic       run;
    logic       even;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    pcs_seq_counter u_seq (
        .clk    (i_clk),
        .rst_n  (rst_n),
        .clear  (!i_enable),
        .hold   (state != ST_RUN),
        .count  (o_gearbox_seq),
        .at_max (seq_at_max)
    );

    assign run  = (state == ST_RUN);
    assign even = ~o_gearbox_seq[0];

    // The block decision is made on the header cycle itself,
    // then carried into the upper-word cycle.
    assign o_insert_idle = run && (even ? !i_valid : idle_odd);

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            delay_cnt   <= '0;
            pause_cnt   <= '0;
            o_pause     <= 1'b1;
            o_ready     <= 1'b0;
            o_running   <= 1'b0;
            o_underflow <= 1'b0;
            idle_odd    <= 1'b0;
            even_xfer   <= 1'b0;
        end else if (!i_enable) begin
            state       <= ST_IDLE;
            delay_cnt   <= '0;
            pause_cnt   <= '0;
            o_pause     <= 1'b1;
            o_ready     <= 1'b0;
            o_running   <= 1'b0;
            o_underflow <= 1'b0;
            idle_odd    <= 1'b0;
            even_xfer   <= 1'b0;
        end else begin
            idle_odd  <= run && even && !i_valid;
            even_xfer <= run && even && i_valid;
            if (run && !even && !i_valid && even_xfer) begin
                o_underflow <= 1'b1;
            end
            unique case (state)
                ST_IDLE: begin
                    state     <= ST_START;
                    delay_cnt <= 4'(START_DELAY - 1);
                end
                ST_START: begin
                    if (delay_cnt == 4'd0) begin
                        state     <= ST_RUN;
                        o_pause   <= 1'b0;
                        o_ready   <= 1'b1;
                        o_running <= 1'b1;
                    end else begin
                        delay_cnt <= delay_cnt - 4'd1;
                    end
                end
                ST_RUN: begin
                    if (seq_at_max) begin
                        state     <= ST_PAUSE;
                        pause_cnt <= 2'(PAUSE_CYCLES - 1);
                        o_pause   <= 1'b1;
                        o_ready   <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (pause_cnt == 2'd0) begin
                        state   <= ST_RUN;
                        o_pause <= 1'b0;
                        o_ready <= 1'b1;
                    end else begin
                        pause_cnt <= pause_cnt - 2'd1;
                    end
                end
            endcase
        end
    end

`ifdef TX_GEARBOX_CTRL_STATS_EN
    // Counted on header cycles: one event per 66b block.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            o_block_count <= '0;
            o_idle_count  <= '0;
        end else if (run && even) begin
            if (i_valid) begin
                o_block_count <= o_block_count + 32'd1;
            end else if (o_idle_count != 16'hFFFF) begin
                o_idle_count <= o_idle_count + 16'd1;
            end
        end
    end
`endif

endmodule
